key_round_sequencer: RTL and testbench
======================================

KEY_ROUND_SEQUENCER -- requirements
Module: key_round_sequencer

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds (10/12/14 legal; other values unsupported).
REQ-002 SHALL have parameter KW, default 4, SelKey width; KW SHALL satisfy 2^KW > NR.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request one key sequence; sampled in IDLE only.
REQ-006 EncEn  input  1  encryption mode select, sampled with Start.
REQ-007 DecEn  input  1  decryption mode select, sampled with Start.
REQ-008 Hold  input  1  pause sequencing (present only with KEY_SEQ_HOLD_EN).
REQ-009 SelKey  output  KW  current round-key index.
REQ-010 RoundValid  output  1  SelKey valid this cycle.
REQ-011 LastRound  output  1  SelKey is the final index of the sequence.
REQ-012 Busy  output  1  sequence in progress.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 ModeDec  output  1  latched mode: 1 = decrypt, 0 = encrypt.
REQ-015 Err  output  1  one-cycle pulse on illegal mode request.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: Start=1 with exactly one of EncEn/DecEn high SHALL go to RUN, latching ModeDec=DecEn.
REQ-018 IDLE: Start=1 with EncEn=DecEn (both 0 or both 1) SHALL pulse Err next cycle and remain IDLE.
REQ-019 First RUN cycle (one cycle after accepted Start): SelKey=0 (encrypt) or NR (decrypt), RoundValid=1, Busy=1.
REQ-020 Each subsequent RUN cycle SHALL increment SelKey (encrypt) or decrement (decrypt) by 1; exactly NR+1 indices issued.
REQ-021 LastRound SHALL be 1 while RUN and SelKey==NR (encrypt) or SelKey==0 (decrypt), else 0.
REQ-022 Cycle after LastRound cycle: state DONE, Done=1, Busy=0, RoundValid=0, SelKey holds last value.
REQ-023 DONE SHALL return to IDLE after exactly one cycle; Start in DONE SHALL be ignored.
REQ-024 Start, EncEn, DecEn changes during RUN/DONE SHALL be ignored; ModeDec SHALL stay latched until next accepted Start.
REQ-025 SelKey SHALL never wrap: no value above NR or below 0 is ever driven.
REQ-026 In IDLE: RoundValid=0, LastRound=0, Busy=0; SelKey holds last value.
REQ-027 Start-to-first-valid latency SHALL be 1 cycle; Start-to-Done latency NR+2 cycles (no Hold).

Reset
REQ-028 rst=1 SHALL immediately force IDLE, SelKey=0, RoundValid=0, LastRound=0, Busy=0, Done=0, ModeDec=0, Err=0, independent of clk.
REQ-029 rst asserted mid-RUN SHALL abort the sequence with no Done pulse; first Start after release starts fresh.

Configuration
REQ-030 Macro KEY_SEQ_HOLD_EN defined: Hold port exists; Hold=1 in RUN SHALL freeze SelKey, LastRound and state while RoundValid=0; Hold=1 during LastRound cycle delays DONE; Hold ignored in IDLE/DONE.
REQ-031 Macro KEY_SEQ_HOLD_EN undefined: Hold port absent; RUN advances every cycle.

Verification
REQ-032 NR=10, Start+EncEn -> SelKey 0,1,...,10 on consecutive cycles, LastRound with 10, Done one cycle later.
REQ-033 NR=10, Start+DecEn -> SelKey 10,9,...,0, LastRound with 0, ModeDec=1, Done one cycle later.
REQ-034 Start with EncEn=DecEn=1, then EncEn=DecEn=0 -> Err pulse each time, Busy stays 0, SelKey unchanged.
REQ-035 NR=14, KW=4, encrypt; rst pulsed when SelKey=5 -> all outputs reset asynchronously, no Done; new decrypt Start yields 14..0.
REQ-036 KEY_SEQ_HOLD_EN, encrypt, Hold=1 for 3 cycles at SelKey=4 -> SelKey stays 4, RoundValid=0 for 3 cycles, then resumes 4,5,...; Done at cycle NR+5 after Start.
REQ-037 Start re-asserted during RUN and in DONE -> ignored; IDLE reached, next Start accepted normally.

Source files
------------

// File: rtl/key_round_sequencer.sv
// key_round_sequencer: issues AES round-key indices 0..NR (encrypt) or NR..0 (decrypt).
// Optional feature macro KEY_SEQ_HOLD_EN adds a Hold input that pauses an in-flight sequence.
//
// state | meaning
// IDLE  | waiting for Start; SelKey keeps the last issued index
// RUN   | one round-key index presented per advancing cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module key_round_sequencer #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic          EncEn,
  input  logic          DecEn,
`ifdef KEY_SEQ_HOLD_EN
  input  logic          Hold,
`endif
  output logic [KW-1:0] SelKey,
  output logic          RoundValid,
  output logic          LastRound,
  output logic          Busy,
  output logic          Done,
  output logic          ModeDec,
  output logic          Err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic [KW-1:0] LastIdx = KW'(NR);

  stateT         state;
  logic [KW-1:0] roundsLeft;
  logic          issueReg;
  logic          holdNow;

`ifdef KEY_SEQ_HOLD_EN
  assign holdNow = Hold;
`else
  assign holdNow = 1'b0;
`endif

  // A held cycle keeps the index on SelKey but withdraws its valid flag.
  assign RoundValid = issueReg & ~holdNow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      SelKey     <= '0;
      roundsLeft <= '0;
      issueReg   <= 1'b0;
      LastRound  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      ModeDec    <= 1'b0;
      Err        <= 1'b0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (EncEn ^ DecEn) begin
              state      <= RUN;
              ModeDec    <= DecEn;
              SelKey     <= DecEn ? LastIdx : '0;
              roundsLeft <= LastIdx;
              issueReg   <= 1'b1;
              LastRound  <= 1'b0;
              Busy       <= 1'b1;
            end else begin
              Err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!holdNow) begin
            // roundsLeft reaching zero marks the final index as already presented.
            if (roundsLeft == '0) begin
              state     <= DONE;
              issueReg  <= 1'b0;
              LastRound <= 1'b0;
              Busy      <= 1'b0;
              Done      <= 1'b1;
            end else begin
              SelKey     <= ModeDec ? (SelKey - 1'b1) : (SelKey + 1'b1);
              roundsLeft <= roundsLeft - 1'b1;
              LastRound  <= (roundsLeft == KW'(1));
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_round_sequencer.sv
// Bench for key_round_sequencer: NR=10 and NR=14 instances share stimulus and are checked
// every cycle against an index-count model; Hold scenarios run when KEY_SEQ_HOLD_EN is defined.
module tb_key_round_sequencer;
  localparam int NA = 10;
  localparam int NB = 14;
  localparam int KW = 4;
  localparam int OW = KW + 6;

  logic clk = 1'b0;
  logic rst, Start, EncEn, DecEn, Hold;
  logic [KW-1:0] selA, selB;
  logic rvA, lrA, busyA, doneA, modeA, errA;
  logic rvB, lrB, busyB, doneB, modeB, errB;
  logic [OW-1:0] obsA, obsB;

  int checks = 0;
  int failures = 0;
  int lastKeyA = 0;
  int lastKeyB = 0;
  bit lastMode = 1'b0;

  always #5 clk = ~clk;

  assign obsA = {selA, rvA, lrA, busyA, doneA, modeA, errA};
  assign obsB = {selB, rvB, lrB, busyB, doneB, modeB, errB};

  key_round_sequencer #(.NR(NA), .KW(KW)) uA (
    .clk(clk), .rst(rst), .Start(Start), .EncEn(EncEn), .DecEn(DecEn),
`ifdef KEY_SEQ_HOLD_EN
    .Hold(Hold),
`endif
    .SelKey(selA), .RoundValid(rvA), .LastRound(lrA), .Busy(busyA),
    .Done(doneA), .ModeDec(modeA), .Err(errA)
  );

  key_round_sequencer #(.NR(NB), .KW(KW)) uB (
    .clk(clk), .rst(rst), .Start(Start), .EncEn(EncEn), .DecEn(DecEn),
`ifdef KEY_SEQ_HOLD_EN
    .Hold(Hold),
`endif
    .SelKey(selB), .RoundValid(rvB), .LastRound(lrB), .Busy(busyB),
    .Done(doneB), .ModeDec(modeB), .Err(errB)
  );

  // pos = number of indices already issued; pos==n+1 is the Done cycle, beyond that idle.
  function automatic logic [OW-1:0] expected(int n, bit dec, int pos, bit hold);
    logic [KW-1:0] key;
    logic v, l, b, d;
    if (pos <= n) begin
      key = KW'(dec ? (n - pos) : pos);
      v = !hold; l = (pos == n); b = 1'b1; d = 1'b0;
    end else begin
      key = KW'(dec ? 0 : n);
      v = 1'b0; l = 1'b0; b = 1'b0; d = (pos == n + 1);
    end
    return {key, v, l, b, d, dec, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; EncEn = 1'b0; DecEn = 1'b0; Hold = 1'b0;
    #1;
    checks++;
    if (obsA !== '0) begin
      failures++;
      $display("FAIL reset_A got=%h exp=%h", obsA, {OW{1'b0}});
    end
    checks++;
    if (obsB !== '0) begin
      failures++;
      $display("FAIL reset_B got=%h exp=%h", obsB, {OW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
    lastKeyA = 0; lastKeyB = 0; lastMode = 1'b0;
  endtask

  task automatic test_sequence(input bit dec, input int holdAt, input int holdLen, input bit junk);
    int posA, posB;
    logic [OW-1:0] expA, expB;
    @(negedge clk);
    Start = 1'b1; EncEn = !dec; DecEn = dec; Hold = 1'b0;
    posA = 0; posB = 0;
    for (int c = 1; c <= NB + 3 + holdLen; c++) begin
      @(negedge clk);
      Hold = (c >= holdAt) && (c < holdAt + holdLen);
      if (junk && posA <= NA + 1) begin
        Start = 1'($urandom); EncEn = 1'($urandom); DecEn = 1'($urandom);
      end else begin
        Start = 1'b0; EncEn = 1'b0; DecEn = 1'b0;
      end
      #1;
      expA = expected(NA, dec, posA, Hold);
      expB = expected(NB, dec, posB, Hold);
      checks++;
      if (obsA !== expA) begin
        failures++;
        $display("FAIL seq_A dec=%0d c=%0d got=%h exp=%h", dec, c, obsA, expA);
      end
      checks++;
      if (obsB !== expB) begin
        failures++;
        $display("FAIL seq_B dec=%0d c=%0d got=%h exp=%h", dec, c, obsB, expB);
      end
      if (posA > NA || !Hold) posA++;
      if (posB > NB || !Hold) posB++;
    end
    Start = 1'b0; EncEn = 1'b0; DecEn = 1'b0; Hold = 1'b0;
    lastKeyA = dec ? 0 : NA;
    lastKeyB = dec ? 0 : NB;
    lastMode = dec;
  endtask

  task automatic test_illegal_mode();
    logic [OW-1:0] expA, expB;
    bit both;
    for (int k = 0; k < 6; k++) begin
      both = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      Start = 1'b1; EncEn = both; DecEn = both;
      @(negedge clk);
      Start = 1'b0; EncEn = 1'($urandom); DecEn = 1'($urandom);
      #1;
      expA = {KW'(lastKeyA), 4'b0000, lastMode, 1'b1};
      expB = {KW'(lastKeyB), 4'b0000, lastMode, 1'b1};
      checks++;
      if (obsA !== expA) begin
        failures++;
        $display("FAIL illegal_err_A k=%0d got=%h exp=%h", k, obsA, expA);
      end
      checks++;
      if (obsB !== expB) begin
        failures++;
        $display("FAIL illegal_err_B k=%0d got=%h exp=%h", k, obsB, expB);
      end
      @(negedge clk);
      #1;
      checks++;
      if (obsA !== {KW'(lastKeyA), 4'b0000, lastMode, 1'b0}) begin
        failures++;
        $display("FAIL illegal_after_A k=%0d got=%h exp=%h", k, obsA,
                 {KW'(lastKeyA), 4'b0000, lastMode, 1'b0});
      end
    end
    EncEn = 1'b0; DecEn = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [OW-1:0] expA, expB;
    @(negedge clk);
    Start = 1'b1; EncEn = 1'b1; DecEn = 1'b0; Hold = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      Start = 1'b0; EncEn = 1'b0;
      #1;
      expA = expected(NA, 1'b0, c - 1, 1'b0);
      expB = expected(NB, 1'b0, c - 1, 1'b0);
      checks++;
      if (obsA !== expA) begin
        failures++;
        $display("FAIL abort_run_A c=%0d got=%h exp=%h", c, obsA, expA);
      end
      checks++;
      if (obsB !== expB) begin
        failures++;
        $display("FAIL abort_run_B c=%0d got=%h exp=%h", c, obsB, expB);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obsA !== '0) begin
      failures++;
      $display("FAIL abort_async_A got=%h exp=%h", obsA, {OW{1'b0}});
    end
    checks++;
    if (obsB !== '0) begin
      failures++;
      $display("FAIL abort_async_B got=%h exp=%h", obsB, {OW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obsB !== '0 || obsA !== '0) begin
        failures++;
        $display("FAIL abort_no_done c=%0d gotA=%h gotB=%h exp=%h", c, obsA, obsB, {OW{1'b0}});
      end
    end
    lastKeyA = 0; lastKeyB = 0; lastMode = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      test_sequence(1'($urandom_range(0, 1)), 0, 0, 1'b1);
    end
  endtask

`ifdef KEY_SEQ_HOLD_EN
  task automatic test_hold();
    test_sequence(1'b0, 5, 3, 1'b0);
    test_sequence(1'b0, 11, 2, 1'b0);
    test_sequence(1'b1, 3, 4, 1'b1);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence(1'b0, 0, 0, 1'b0);
    test_sequence(1'b1, 0, 0, 1'b0);
    test_illegal_mode();
    test_reset_mid_run();
    test_sequence(1'b1, 0, 0, 1'b0);
    test_back_to_back();
`ifdef KEY_SEQ_HOLD_EN
    test_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
